cpu_pipe3_gpio: RTL
===================

// Module: cpu_pipe3_gpio
// PURPOSE
//  Parametrised 3-stage RV32I-subset core (FETCH / EXECUTE / WRITEBACK) for the lab top level.
//  Adds the following over the first-generation core:
//    - WB->EX forwarding.
//    - Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and JAL, with a flush.
//    - N memory-mapped GPIO in/out channels through CSRRW.
//    - A stall input.
//  Reuses inst_decoder, control_fields, alu and regfile.
// PARAMETERS
//  IMEM_AW        12      instruction memory word-address width (depth 2**IMEM_AW)
//  N_GPIO_IN      1       number of 32-bit input channels
//  N_GPIO_OUT     1       number of 32-bit output channels
//  GPIO_IN_BASE   12'hF00 CSR number of input channel 0 (channel k = base+k)
//  GPIO_OUT_BASE  12'hF02 CSR number of output channel 0 (channel k = base+k)
//  RESET_PC       32'h0   byte address fetched first after reset
// PORTS
//  clk             in   1                 clock, all state on rising edge
//  rst             in   1                 asynchronous reset, active-high
//  stall           in   1                 1 = freeze whole pipeline this cycle
//  imem_addr       out  IMEM_AW           word address = pc_F[IMEM_AW+1:2]
//  imem_rdata      in   32                instruction at imem_addr, combinational read
//  gpio_in         in   32*N_GPIO_IN      channel k at [32k+31:32k]
//  gpio_out        out  32*N_GPIO_OUT     registered output channels
//  gpio_out_strobe out  N_GPIO_OUT        1-cycle pulse when channel k is written
// BEHAVIOUR
//  Reset (async, rst=1):
//    - pc_F <= RESET_PC; instr_EX <= NOP (32'h00000013); regwrite_WB <= 0.
//    - gpio_out <= 0; gpio_out_strobe <= 0; regfile cleared.
//  FETCH: each unstalled edge, instr_EX <= imem_rdata and pc_EX <= pc_F.
//    - pc_F advances by 4, or loads the redirect target.
//    - pc_F wraps modulo 2**(IMEM_AW+2).
//  EXECUTE: decode, regfile read and ALU operate on instr_EX.
//    - Operand forwarding: if regwrite_WB && rd_WB!=0 && rd_WB==rsN_EX, the operand is data_WB,
//      else the regfile readdata.
//    - ALU B: rs2 (R-type, branch compare) or sign-extended imm12 (I-type).
//  Branch/JAL resolved in EX:
//    - Target = pc_EX + sign-extended B/J immediate.
//    - Taken: pc_F <= target and instr_EX <= NOP (1-cycle flush penalty).
//    - Not taken: no bubble.
//    - JAL writes pc_EX+4 to rd.
//    - Comparisons: signed for BLT/BGE, unsigned for BLTU/BGEU.
//    - Target bits [1:0] are ignored (forced to word alignment).
//  WRITEBACK: on the edge ending EX, the WB registers latch rd, regsel, regwrite and the result.
//    - The regfile writes data_WB at the next edge.
//    - Writes to x0 are discarded.
//    - WB sources (regsel mux):
//        - ALU result
//        - LUI {imm20,12'b0}
//        - AUIPC pc_EX+{imm20,12'b0}
//        - JAL link
//        - GPIO input
//  CSRRW rd, csr, rs1:
//    - If csr == GPIO_IN_BASE+k (k<N_GPIO_IN), rd <= gpio_in channel k, sampled in EX.
//    - If csr == GPIO_OUT_BASE+k (k<N_GPIO_OUT):
//        - gpio_out channel k <= forwarded rs1 on the edge ending EX.
//        - gpio_out_strobe[k] = 1 for exactly the following cycle.
//    - Unmapped csr: no output write, rd <= 0.
//    - If ranges overlap, the input read and output write both occur.
//  Unsupported opcodes: executed as NOP (no regfile write, no GPIO write, no redirect).
//  stall=1:
//    - pc_F, instr_EX, pc_EX and the WB registers hold.
//    - regwrite is suppressed so no double write occurs.
//    - gpio_out holds; gpio_out_strobe is 0.
//    - stall takes priority over a taken branch, which resolves when stall drops.
//  Reset mid-operation: takes effect immediately regardless of stall or in-flight instructions.
//    - The first fetch is from RESET_PC on the first edge after rst falls.
// TESTING
//  addi x1,x0,5; addi x2,x1,3 back-to-back -> x2=8 (forwarding), x1=5.
//  addi x1,x0,1; beq x1,x1,+8; addi x3,x0,9; addi x4,x0,7
//    -> x3 stays 0, x4=7, and exactly one NOP bubble is seen in EX.
//  jal x5,+12 at pc 0x10 -> x5=0x14, next executed pc=0x1C.
//  N_GPIO_OUT=2: lui x1,0x12345; csrrw x0,0xF03,x1
//    -> gpio_out[63:32]=32'h12345000, gpio_out_strobe=2'b10 for 1 cycle, channel 0 unchanged.
//  gpio_in=32'h0001FFFF; csrrw x6,0xF00,x0 -> x6=32'h0001FFFF.
//    - Then csrrw x7,0xABC,x0 -> x7=0, and no strobe.
//  Assert stall for 3 cycles mid-program -> pc and registers frozen, final state identical to the
//  unstalled run.
//    - Then assert rst mid-program -> gpio_out=0 and pc=RESET_PC asynchronously.

Source files
------------

// File: rtl/cpu_pipe3_gpio.sv
// cpu_pipe3_gpio: three-stage RV32I-subset core (FETCH / EXECUTE / WRITEBACK)
// with WB->EX forwarding, branches and JAL that are resolved in EX, a global
// stall, and memory-mapped GPIO channels reached through CSRRW.
//
// Flow control: the only flow control is the stall input. It is a hold, not a
// valid/ready handshake. While stall=1, every pipeline register keeps its
// value, the regfile write port is disabled and the GPIO strobe is driven low.
// In the first cycle with stall=0, the held instruction completes exactly once.
module cpu_pipe3_gpio #(
  parameter int          IMEM_AW       = 12,
  parameter int          N_GPIO_IN     = 1,
  parameter int          N_GPIO_OUT    = 1,
  parameter logic [11:0] GPIO_IN_BASE  = 12'hF00,
  parameter logic [11:0] GPIO_OUT_BASE = 12'hF02,
  parameter logic [31:0] RESET_PC      = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  output logic [IMEM_AW-1:0]      imem_addr,
  input  logic [31:0]             imem_rdata,
  input  logic [32*N_GPIO_IN-1:0] gpio_in,
  output logic [32*N_GPIO_OUT-1:0] gpio_out,
  output logic [N_GPIO_OUT-1:0]   gpio_out_strobe
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  // The PC wraps inside the instruction memory's byte address space.
  localparam logic [31:0] PC_MASK = 32'((64'd1 << (IMEM_AW + 2)) - 64'd1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    SEL_ALU, SEL_LUI, SEL_AUIPC, SEL_LINK, SEL_GPIO
  } wb_sel_t;

  // Pipeline state
  logic [31:0] pc_f;
  logic [31:0] pc_ex;
  logic [31:0] instr_ex;
  logic        regwrite_wb;
  logic [4:0]  rd_wb;
  logic [31:0] data_wb;
  logic [31:0] regs [32];

  // EX decode fields
  logic [6:0]  opcode;
  logic [4:0]  rd_ex, rs1_ex, rs2_ex;
  logic [2:0]  f3;
  logic        f7b5;
  logic [11:0] csr_num;
  logic [31:0] imm_i, imm_b, imm_j, imm_u;

  // EX control
  alu_op_t     alu_op;
  wb_sel_t     wb_sel;
  logic        use_imm;
  logic        regwrite_ex;
  logic        is_branch;
  logic        is_jal;
  logic        is_csr;

  // EX datapath
  logic [31:0] fwd_a, fwd_b, alu_b, alu_res;
  logic        br_cond;
  logic        taken_ex;
  logic [31:0] target_ex;
  logic [31:0] gpio_rd;
  logic [N_GPIO_OUT-1:0] out_hit;
  logic [31:0] result_ex;

  assign imem_addr = pc_f[IMEM_AW+1:2];

  assign opcode  = instr_ex[6:0];
  assign rd_ex   = instr_ex[11:7];
  assign f3      = instr_ex[14:12];
  assign rs1_ex  = instr_ex[19:15];
  assign rs2_ex  = instr_ex[24:20];
  assign f7b5    = instr_ex[30];
  assign csr_num = instr_ex[31:20];

  assign imm_i = {{20{instr_ex[31]}}, instr_ex[31:20]};
  assign imm_b = {{19{instr_ex[31]}}, instr_ex[31], instr_ex[7],
                  instr_ex[30:25], instr_ex[11:8], 1'b0};
  assign imm_j = {{11{instr_ex[31]}}, instr_ex[31], instr_ex[19:12],
                  instr_ex[20], instr_ex[30:21], 1'b0};
  assign imm_u = {instr_ex[31:12], 12'b0};

  // Map funct3/funct7 to an ALU operation; SUB exists only in R-type.
  function automatic alu_op_t alu_sel(input logic [2:0] fn3, input logic b30,
                                      input logic r_type);
    alu_op_t op;
    case (fn3)
      3'b000:  op = (r_type && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Decode: anything not listed below falls through as a NOP.
  always_comb begin
    alu_op      = ALU_ADD;
    wb_sel      = SEL_ALU;
    use_imm     = 1'b0;
    regwrite_ex = 1'b0;
    is_branch   = 1'b0;
    is_jal      = 1'b0;
    is_csr      = 1'b0;
    case (opcode)
      OPC_OP: begin
        regwrite_ex = 1'b1;
        alu_op      = alu_sel(f3, f7b5, 1'b1);
      end
      OPC_OPIMM: begin
        regwrite_ex = 1'b1;
        use_imm     = 1'b1;
        alu_op      = alu_sel(f3, f7b5, 1'b0);
      end
      OPC_LUI: begin
        regwrite_ex = 1'b1;
        wb_sel      = SEL_LUI;
      end
      OPC_AUIPC: begin
        regwrite_ex = 1'b1;
        wb_sel      = SEL_AUIPC;
      end
      OPC_JAL: begin
        regwrite_ex = 1'b1;
        wb_sel      = SEL_LINK;
        is_jal      = 1'b1;
      end
      OPC_BRANCH: begin
        // funct3 010/011 are not branch encodings.
        is_branch = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b001) begin
          regwrite_ex = 1'b1;
          wb_sel      = SEL_GPIO;
          is_csr      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Operand fetch with WB->EX forwarding. Results two instructions back are
  // already in the regfile, so a single bypass is enough.
  always_comb begin
    fwd_a = regs[rs1_ex];
    fwd_b = regs[rs2_ex];
    if (regwrite_wb && (rd_wb != 5'd0) && (rd_wb == rs1_ex)) fwd_a = data_wb;
    if (regwrite_wb && (rd_wb != 5'd0) && (rd_wb == rs2_ex)) fwd_b = data_wb;
  end

  assign alu_b = use_imm ? imm_i : fwd_b;

  // ALU
  always_comb begin
    alu_res = fwd_a + alu_b;
    case (alu_op)
      ALU_ADD:  alu_res = fwd_a + alu_b;
      ALU_SUB:  alu_res = fwd_a - alu_b;
      ALU_SLL:  alu_res = fwd_a << alu_b[4:0];
      ALU_SLT:  alu_res = {31'b0, $signed(fwd_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'b0, fwd_a < alu_b};
      ALU_XOR:  alu_res = fwd_a ^ alu_b;
      ALU_SRL:  alu_res = fwd_a >> alu_b[4:0];
      ALU_SRA:  alu_res = $signed(fwd_a) >>> alu_b[4:0];
      ALU_OR:   alu_res = fwd_a | alu_b;
      ALU_AND:  alu_res = fwd_a & alu_b;
      default:  alu_res = fwd_a + alu_b;
    endcase
  end

  // Branch condition: BLT/BGE compare signed, BLTU/BGEU compare unsigned.
  always_comb begin
    br_cond = 1'b0;
    case (f3)
      3'b000:  br_cond = (fwd_a == fwd_b);
      3'b001:  br_cond = (fwd_a != fwd_b);
      3'b100:  br_cond = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  br_cond = (fwd_a <  fwd_b);
      3'b111:  br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign taken_ex  = is_jal | (is_branch & br_cond);
  // The target is word-aligned by dropping bits [1:0], then wrapped.
  assign target_ex = (pc_ex + (is_jal ? imm_j : imm_b)) & PC_MASK & ~32'h3;

  // GPIO CSR address match. Input and output ranges are checked
  // independently, so an overlapping CSR performs both the read and the write.
  always_comb begin
    gpio_rd = '0;
    out_hit = '0;
    for (int k = 0; k < N_GPIO_IN; k++) begin
      if (csr_num == GPIO_IN_BASE + 12'(k)) gpio_rd = gpio_in[32*k +: 32];
    end
    for (int k = 0; k < N_GPIO_OUT; k++) begin
      out_hit[k] = (csr_num == GPIO_OUT_BASE + 12'(k));
    end
  end

  // Writeback source select. A CSR that is not an input channel reads as 0.
  always_comb begin
    result_ex = alu_res;
    case (wb_sel)
      SEL_ALU:   result_ex = alu_res;
      SEL_LUI:   result_ex = imm_u;
      SEL_AUIPC: result_ex = pc_ex + imm_u;
      SEL_LINK:  result_ex = pc_ex + 32'd4;
      SEL_GPIO:  result_ex = gpio_rd;
      default:   result_ex = alu_res;
    endcase
  end

  // FETCH: advance or redirect the PC. A taken branch or JAL squashes the
  // instruction fetched behind it by loading a NOP into EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f     <= RESET_PC;
      pc_ex    <= RESET_PC;
      instr_ex <= NOP;
    end else if (!stall) begin
      pc_ex <= pc_f;
      if (taken_ex) begin
        pc_f     <= target_ex;
        instr_ex <= NOP;
      end else begin
        pc_f     <= (pc_f + 32'd4) & PC_MASK;
        instr_ex <= imem_rdata;
      end
    end
  end

  // WRITEBACK registers: capture the EX result on the edge that ends EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_wb <= 1'b0;
      rd_wb       <= 5'd0;
      data_wb     <= 32'd0;
    end else if (!stall) begin
      regwrite_wb <= regwrite_ex;
      rd_wb       <= rd_ex;
      data_wb     <= result_ex;
    end
  end

  // Regfile write port. It is disabled during a stall so the held WB entry
  // is written only once, on the first unstalled edge. Writes to x0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (regwrite_wb && !stall && (rd_wb != 5'd0)) begin
      regs[rd_wb] <= data_wb;
    end
  end

  // GPIO output channels. A matched CSRRW writes the forwarded rs1 value and
  // raises that channel's strobe for the following cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out        <= '0;
      gpio_out_strobe <= '0;
    end else if (stall) begin
      gpio_out_strobe <= '0;
    end else begin
      gpio_out_strobe <= is_csr ? out_hit : '0;
      for (int k = 0; k < N_GPIO_OUT; k++) begin
        if (is_csr && out_hit[k]) gpio_out[32*k +: 32] <= fwd_a;
      end
    end
  end

endmodule
